// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that lends one UART transmitter to NUM_REQ byte-stream clients,
// holding the grant for a whole message up to a MAX_BURST byte fairness cap.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int MAX_BURST    = 16,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   grant,
  output logic [NUM_REQ-1:0]   ack,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic                 timeout_err,
  output logic [1:0]           dbg_state
);

  // Handshake: a client raises req[i] with req_data/req_last stable and holds them until
  // the cycle ack[i] is high; it may present its next byte in the cycle after ack.
  localparam int PW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT_BUSY, S_WAIT_DONE} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [BW-1:0]        burst_q, burst_d;
  logic                 last_q, last_d;
  logic [TW-1:0]        tmo_q, tmo_d;
  logic                 tmo_err_q, tmo_err_d;

  logic                 win_found;
  logic [PW-1:0]        win_idx;
  logic [PW-1:0]        win_cand;
  int                   idx;
  logic [PW-1:0]        owner_inc;
  logic                 burst_cap;

  // Descending scan so the last hit wins: that is the requester closest to ptr_q.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_cand  = '0;
    idx       = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      win_cand = PW'(idx);
      if (req[win_cand]) begin
        win_found = 1'b1;
        win_idx   = win_cand;
      end
    end
  end

  assign owner_inc = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  assign burst_cap = (MAX_BURST != 0) && (burst_q == BW'(MAX_BURST));

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    ptr_d     = ptr_q;
    tx_data_d = tx_data_q;
    burst_d   = burst_q;
    last_d    = last_q;
    tmo_d     = tmo_q;
    tmo_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!tx_busy && win_found) begin
          grant_d   = '0;
          grant_d[win_idx] = 1'b1;
          owner_d   = win_idx;
          tx_data_d = req_data[8*win_idx +: 8];
          burst_d   = BW'(1);
          last_d    = req_last[win_idx];
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        tmo_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        // A busy rise on the same edge as the timeout takes priority.
        if (tx_busy) begin
          state_d = S_WAIT_DONE;
        end else if (tmo_q == TW'(BUSY_TIMEOUT - 1)) begin
          tmo_err_d = 1'b1;
          grant_d   = '0;
          ptr_d     = owner_inc;
          state_d   = S_IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_WAIT_DONE: begin
        if (!tx_busy) begin
          if (last_q || !req[owner_q] || burst_cap) begin
            grant_d = '0;
            ptr_d   = owner_inc;
            state_d = S_IDLE;
          end else begin
            tx_data_d = req_data[8*owner_q +: 8];
            last_d    = req_last[owner_q];
            burst_d   = (burst_q == {BW{1'b1}}) ? burst_q : burst_q + 1'b1;
            state_d   = S_LOAD;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
      tx_data_q <= 8'h00;
      burst_q   <= '0;
      last_q    <= 1'b0;
      tmo_q     <= '0;
      tmo_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      ptr_q     <= ptr_d;
      tx_data_q <= tx_data_d;
      burst_q   <= burst_d;
      last_q    <= last_d;
      tmo_q     <= tmo_d;
      tmo_err_q <= tmo_err_d;
    end
  end

  assign tx_start    = (state_q == S_LOAD);
  assign ack         = tx_start ? grant_q : '0;
  assign grant       = grant_q;
  assign tx_data     = tx_data_q;
  assign timeout_err = tmo_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: client queues, a UART busy model and a start-order scoreboard.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 3;
  localparam int BT = 15;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NR-1:0]   req;
  logic [8*NR-1:0] req_data;
  logic [NR-1:0]   req_last;
  logic [NR-1:0]   grant;
  logic [NR-1:0]   ack;
  logic            tx_start;
  logic [7:0]      tx_data;
  logic            tx_busy;
  logic            timeout_err;
  logic [1:0]      dbg_state;

  uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .req_last(req_last),
    .grant(grant), .ack(ack), .tx_start(tx_start), .tx_data(tx_data),
    .tx_busy(tx_busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- client and UART models ----------------
  logic [8:0]      rq [NR][$];
  logic [NR+7:0]   exp_q [$];
  logic [NR-1:0]   drv_pend;
  bit              uart_dead = 1'b0;
  int              ack_cnt [NR];

  task automatic push_req(input int r, input logic [7:0] d, input logic last);
    rq[r].push_back({last, d});
  endtask

  task automatic push_exp(input int r, input logic [7:0] d);
    logic [NR-1:0] g;
    g = '0;
    g[r] = 1'b1;
    exp_q.push_back({g, d});
  endtask

  function automatic bit rq_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  initial begin
    req = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      drv_pend = ack;
      @(posedge clk);
      #1;
      for (int i = 0; i < NR; i++) begin
        if (drv_pend[i] && rq[i].size() != 0) void'(rq[i].pop_front());
        if (rq[i].size() != 0) begin
          req[i] = 1'b1;
          req_data[8*i +: 8] = rq[i][0][7:0];
          req_last[i] = rq[i][0][8];
        end else begin
          req[i] = 1'b0;
          req_data[8*i +: 8] = 8'h00;
          req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int busy_len;
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_start && !uart_dead) begin
        busy_len = $urandom_range(2, 8);
        @(posedge clk);
        #1 tx_busy = 1'b1;
        repeat (busy_len) @(posedge clk);
        #1 tx_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  initial begin
    logic [NR+7:0] e;
    logic [7:0]    prev_data;
    bit            busy_high;
    bit            busy_done;
    prev_data = 8'h00;
    busy_high = 1'b0;
    busy_done = 1'b1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_data = tx_data;
        busy_done = 1'b1;
      end else begin
        check_eq("grant_onehot0", $onehot0(grant), 1);
        check_eq("ack_in_grant", ack & ~grant, 0);
        check_eq("start_vs_ack", tx_start, |ack);
        check_eq("no_stray_timeout", timeout_err & ~uart_dead, 0);
        if (tx_data !== prev_data) check_eq("tx_data_change_in_load", tx_start, 1);
        prev_data = tx_data;
        if (tx_start) begin
          if (exp_q.size() == 0) begin
            check_eq("unexpected_start", tx_data, 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check_eq("tx_data", tx_data, e[7:0]);
            check_eq("grant", grant, e[NR+7:8]);
          end
          check_eq("busy_cycle_between_starts", busy_done, 1);
          busy_done = 1'b0;
          for (int i = 0; i < NR; i++) ack_cnt[i] += int'(ack[i]);
        end
        if (tx_busy) busy_high = 1'b1;
        if (!tx_busy && busy_high) begin
          busy_high = 1'b0;
          busy_done = 1'b1;
        end
        if (timeout_err) busy_done = 1'b1;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!(exp_q.size() == 0 && rq_empty() && dbg_state == 2'd0 && !tx_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, n < 2000, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_grant"}, grant, 0);
    check_eq({tag, "_ack"}, ack, 0);
    check_eq({tag, "_tx_start"}, tx_start, 0);
    check_eq({tag, "_tx_data"}, tx_data, 0);
    check_eq({tag, "_timeout_err"}, timeout_err, 0);
    check_eq({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- tests ----------------
  initial begin
    int n;
    int t0;
    logic [7:0] b [5];

    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    #1;
    check_reset_outputs("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single requester: one-cycle latency and release.
    push_req(0, 8'hA5, 1'b1);
    push_exp(0, 8'hA5);
    n = 0;
    while (!req[0] && n < 20) begin @(negedge clk); n++; end
    t0 = cyc;
    n = 0;
    while (!tx_start && n < 20) begin @(negedge clk); n++; end
    check_eq("start_latency", cyc - t0, 1);
    check_eq("single_ack", ack, 4'b0001);
    wait_idle("single_idle");
    check_eq("single_grant_released", grant, 0);

    // Pointer advanced past requester 0: requester 1 goes first.
    push_req(0, 8'hC3, 1'b1);
    push_req(1, 8'hD4, 1'b1);
    push_exp(1, 8'hD4);
    push_exp(0, 8'hC3);
    wait_idle("ptr_idle");

    // All four requesting from reset: order 0,1,2,3,0.
    do_reset();
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
    push_req(0, b[0], 1'b1);
    push_req(0, b[4], 1'b1);
    for (int i = 1; i < NR; i++) push_req(i, b[i], 1'b1);
    for (int i = 0; i < NR; i++) push_exp(i, b[i]);
    push_exp(0, b[4]);
    wait_idle("rr_idle");

    // Three-byte message from 2 completes before waiting requester 1.
    do_reset();
    push_req(1, 8'h01, 1'b1);
    push_exp(1, 8'h01);
    wait_idle("msg_setup_idle");
    for (int i = 0; i < NR; i++) ack_cnt[i] = 0;
    push_req(2, 8'h11, 1'b0);
    push_req(2, 8'h22, 1'b0);
    push_req(2, 8'h33, 1'b1);
    push_req(1, 8'h44, 1'b1);
    push_exp(2, 8'h11);
    push_exp(2, 8'h22);
    push_exp(2, 8'h33);
    push_exp(1, 8'h44);
    wait_idle("msg_idle");
    check_eq("msg_acks_r2", ack_cnt[2], 3);
    check_eq("msg_acks_r1", ack_cnt[1], 1);

    // Burst cap of MB bytes, then requester 3, then the rest of 0 (ends by abandon).
    do_reset();
    for (int i = 0; i < 5; i++) begin
      b[i] = 8'($urandom_range(0, 255));
      push_req(0, b[i], 1'b0);
    end
    push_req(3, 8'h3C, 1'b1);
    for (int i = 0; i < MB; i++) push_exp(0, b[i]);
    push_exp(3, 8'h3C);
    for (int i = MB; i < 5; i++) push_exp(0, b[i]);
    wait_idle("burst_idle");

    // UART never goes busy: timeout, release, next requester served.
    do_reset();
    uart_dead = 1'b1;
    push_req(0, 8'h5A, 1'b1);
    push_req(1, 8'h6B, 1'b1);
    push_exp(0, 8'h5A);
    push_exp(1, 8'h6B);
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (!tx_start && n < 60) begin @(negedge clk); n++; end
      check_eq("tmo_start_seen", n < 60, 1);
      t0 = cyc;
      n = 0;
      while (!timeout_err && n < 60) begin @(negedge clk); n++; end
      check_eq("tmo_seen", n < 60, 1);
      check_eq("tmo_latency", cyc - t0 - 1, BT);
      check_eq("tmo_grant", grant, 0);
      @(negedge clk);
      check_eq("tmo_pulse_width", timeout_err, 0);
    end
    uart_dead = 1'b0;
    wait_idle("tmo_idle");

    // Asynchronous reset while waiting for the frame to finish.
    push_req(0, 8'h77, 1'b1);
    push_exp(0, 8'h77);
    n = 0;
    while (dbg_state != 2'd3 && n < 40) begin @(negedge clk); n++; end
    check_eq("wait_done_reached", n < 40, 1);
    #2 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    push_req(2, 8'h99, 1'b1);
    push_exp(2, 8'h99);
    wait_idle("post_reset_idle");

    check_eq("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
